// File: rtl/fetch_unit_if.sv
// ROM read bus between the fetch unit (master) and instruction ROM (slave).
// rom_req/rom_addr are held by the master until the slave strobes rom_valid.
interface fetch_unit_if #(
   parameter int ADDR_WIDTH = 8,
   parameter int DATA_WIDTH = 16
);
   logic                  rom_req;
   logic [ADDR_WIDTH-1:0] rom_addr;
   logic [DATA_WIDTH-1:0] rom_rdata;
   logic                  rom_valid;

   modport master (output rom_req, rom_addr, input rom_rdata, rom_valid);
   modport slave  (input rom_req, rom_addr, output rom_rdata, rom_valid);
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC, ROM request handshake, IR latch, PC redirects.
// Optional wait-cycle watchdog is compiled in with FETCH_TIMEOUT_EN.
module fetch_unit #(
   parameter int                    INSTRUCTION_WIDTH = 16,
   parameter int                    ADDR_WIDTH        = 8,
   parameter logic [ADDR_WIDTH-1:0] RESET_PC          = '0,
   parameter int                    TIMEOUT_CYCLES    = 15
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         fetch_req,
   input  logic                         pc_load,
   input  logic [ADDR_WIDTH-1:0]        pc_target,
   fetch_unit_if.master                 rom,
   output logic [INSTRUCTION_WIDTH-1:0] instruct,
   output logic                         fetch_done,
   output logic                         busy,
   output logic [ADDR_WIDTH-1:0]        pc,
   output logic [ADDR_WIDTH-1:0]        pc_plus1,
   output logic                         fetch_err
);
   typedef enum logic {IDLE, WAIT} state_t;

   state_t                       state, state_nx;
   logic [ADDR_WIDTH-1:0]        pc_q, pc_nx, pend_pc;
   logic                         pend_vld;
   logic [INSTRUCTION_WIDTH-1:0] ir;
   logic                         done_q, err_q;
   logic                         timeout, finish;

`ifdef FETCH_TIMEOUT_EN
   localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
   logic [CW-1:0] wait_cnt;

   // Counter rests at zero outside WAIT, so it starts clean on every fetch.
   always_ff @(posedge clk) begin
      if (reset || state != WAIT) wait_cnt <= '0;
      else if (!rom.rom_valid)    wait_cnt <= wait_cnt + 1'b1;
   end

   assign timeout = (state == WAIT) && !rom.rom_valid &&
                    (wait_cnt == CW'(TIMEOUT_CYCLES - 1));
`else
   logic unused_timeout;
   assign unused_timeout = (TIMEOUT_CYCLES != 0);
   assign timeout        = 1'b0;
`endif

   assign finish = (state == WAIT) && (rom.rom_valid || timeout);

   always_comb begin
      state_nx = state;
      pc_nx    = pc_q;
      case (state)
         IDLE: begin
            if (pc_load)   pc_nx    = pc_target;
            if (fetch_req) state_nx = WAIT;
         end
         WAIT: begin
            if (finish) begin
               state_nx = IDLE;
               // A redirect always beats the sequential increment; a timeout keeps PC.
               if (pc_load)            pc_nx = pc_target;
               else if (pend_vld)      pc_nx = pend_pc;
               else if (rom.rom_valid) pc_nx = pc_q + 1'b1;
            end
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= IDLE;
         pc_q     <= RESET_PC;
         ir       <= '0;
         pend_vld <= 1'b0;
         pend_pc  <= '0;
         done_q   <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         state  <= state_nx;
         pc_q   <= pc_nx;
         done_q <= finish;
         err_q  <= timeout;
         if (state == WAIT && rom.rom_valid) ir <= rom.rom_rdata;
         else if (timeout)                   ir <= '0;
         if (finish) begin
            pend_vld <= 1'b0;
         end else if (state == WAIT && pc_load) begin
            pend_vld <= 1'b1;
            pend_pc  <= pc_target;
         end
      end
   end

   assign rom.rom_req  = (state == WAIT);
   assign rom.rom_addr = pc_q;
   assign instruct     = ir;
   assign fetch_done   = done_q;
   assign busy         = (state == WAIT);
   assign pc           = pc_q;
   assign pc_plus1     = pc_q + 1'b1;
   assign fetch_err    = err_q;
endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed vector table, corner sequences, and randomized
// fetch transactions checked against a transaction-level PC/IR model.
module tb_fetch_unit;
   logic        clk = 1'b0;
   logic        reset, fetch_req, pc_load;
   logic [7:0]  pc_target;
   logic [15:0] instruct;
   logic        fetch_done, busy, fetch_err;
   logic [7:0]  pc, pc_plus1;
   int          tests = 0, fails = 0;

   fetch_unit_if #(.ADDR_WIDTH(8), .DATA_WIDTH(16)) rom_bus ();

   fetch_unit #(.INSTRUCTION_WIDTH(16), .ADDR_WIDTH(8), .RESET_PC(8'h00),
                .TIMEOUT_CYCLES(15)) dut (
      .clk(clk), .reset(reset), .fetch_req(fetch_req), .pc_load(pc_load),
      .pc_target(pc_target), .rom(rom_bus), .instruct(instruct),
      .fetch_done(fetch_done), .busy(busy), .pc(pc), .pc_plus1(pc_plus1),
      .fetch_err(fetch_err));

   always #5 clk = ~clk;

   typedef struct {
      logic        rst;
      logic        ld;
      logic [7:0]  tgt;
      int          waits;
      logic [15:0] data;
      logic        mid_ld;
      logic [7:0]  mid_tgt;
      logic [7:0]  exp_addr;
      logic [7:0]  exp_pc;
   } vec_t;

   vec_t tbl[9];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic do_reset();
      reset = 1'b1;
      tick();
      reset = 1'b0;
   endtask

   // One full fetch starting in the current (IDLE) cycle; returns in the done cycle.
   task automatic do_fetch(input logic ld, input logic [7:0] tgt, input int waits,
                           input logic [15:0] data, input logic mid_ld,
                           input logic [7:0] mid_tgt, input logic [7:0] exp_addr,
                           input logic [7:0] exp_pc, input logic noise);
      logic       bad;
      logic [7:0] e1;
      fetch_req = 1'b1; pc_load = ld; pc_target = tgt;
      tick();
      fetch_req = 1'b0; pc_load = 1'b0;
      chk("rom_req_wait", rom_bus.rom_req, 1);
      chk("rom_addr", rom_bus.rom_addr, exp_addr);
      chk("busy_wait", busy, 1);
      bad = 1'b0;
      for (int w = 0; w < waits; w++) begin
         if (mid_ld && w == 0) begin pc_load = 1'b1; pc_target = mid_tgt; end
         if (noise) fetch_req = 1'($urandom % 2);
         tick();
         pc_load = 1'b0; fetch_req = 1'b0;
         if (rom_bus.rom_req !== 1'b1 || rom_bus.rom_addr !== exp_addr || fetch_done !== 1'b0)
            bad = 1'b1;
      end
      chk("wait_stable", bad, 0);
      rom_bus.rom_valid = 1'b1; rom_bus.rom_rdata = data;
      if (noise) fetch_req = 1'($urandom % 2);
      tick();
      rom_bus.rom_valid = 1'b0; rom_bus.rom_rdata = 16'($urandom); fetch_req = 1'b0;
      e1 = exp_pc + 8'd1;
      chk("fetch_done", fetch_done, 1);
      chk("instruct", instruct, data);
      chk("pc", pc, exp_pc);
      chk("pc_plus1", pc_plus1, e1);
      chk("busy_done", busy, 0);
      chk("rom_req_done", rom_bus.rom_req, 0);
      chk("fetch_err_done", fetch_err, 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0]  mpc, t, mt, ea, ep;
      logic [15:0] mir, d;
      logic        l, m, sl;
      int          wt, cnt;

      tbl[0] = '{1'b1, 1'b0, 8'h00, 0, 16'h1234, 1'b0, 8'h00, 8'h00, 8'h01};
      tbl[1] = '{1'b1, 1'b0, 8'h00, 3, 16'hA001, 1'b0, 8'h00, 8'h00, 8'h01};
      tbl[2] = '{1'b0, 1'b0, 8'h00, 3, 16'hA002, 1'b0, 8'h00, 8'h01, 8'h02};
      tbl[3] = '{1'b0, 1'b0, 8'h00, 3, 16'hA003, 1'b0, 8'h00, 8'h02, 8'h03};
      tbl[4] = '{1'b0, 1'b0, 8'h00, 3, 16'hA004, 1'b0, 8'h00, 8'h03, 8'h04};
      tbl[5] = '{1'b0, 1'b1, 8'h40, 0, 16'h5555, 1'b0, 8'h00, 8'h40, 8'h41};
      tbl[6] = '{1'b0, 1'b1, 8'h04, 1, 16'h6666, 1'b0, 8'h00, 8'h04, 8'h05};
      tbl[7] = '{1'b0, 1'b0, 8'h00, 2, 16'h7777, 1'b1, 8'h80, 8'h05, 8'h80};
      tbl[8] = '{1'b0, 1'b1, 8'hFF, 0, 16'h8888, 1'b0, 8'h00, 8'hFF, 8'h00};

      reset = 1'b1; fetch_req = 1'b0; pc_load = 1'b0; pc_target = 8'h00;
      rom_bus.rom_valid = 1'b0; rom_bus.rom_rdata = 16'h0000;
      tick(); tick();
      chk("rst_rom_req", rom_bus.rom_req, 0);
      chk("rst_rom_addr", rom_bus.rom_addr, 8'h00);
      chk("rst_instruct", instruct, 0);
      chk("rst_pc", pc, 8'h00);
      chk("rst_busy", busy, 0);
      chk("rst_done", fetch_done, 0);
      chk("rst_err", fetch_err, 0);
      reset = 1'b0;

      foreach (tbl[i]) begin
         if (tbl[i].rst) do_reset();
         do_fetch(tbl[i].ld, tbl[i].tgt, tbl[i].waits, tbl[i].data, tbl[i].mid_ld,
                  tbl[i].mid_tgt, tbl[i].exp_addr, tbl[i].exp_pc, 1'b0);
      end
      tick();
      chk("done_one_cycle", fetch_done, 0);

      // Redirect in IDLE without fetch, then wraparound of pc_plus1.
      pc_load = 1'b1; pc_target = 8'hFF;
      tick();
      pc_load = 1'b0;
      chk("idle_load_pc", pc, 8'hFF);
      chk("pc_plus1_wrap", pc_plus1, 8'h00);
      chk("ir_kept_on_load", instruct, 16'h8888);

      // Stray ROM strobe while idle must be ignored.
      rom_bus.rom_valid = 1'b1; rom_bus.rom_rdata = 16'hDEAD;
      tick();
      rom_bus.rom_valid = 1'b0;
      chk("stray_ir", instruct, 16'h8888);
      chk("stray_pc", pc, 8'hFF);
      chk("stray_done", fetch_done, 0);
      do_fetch(1'b0, 8'h00, 1, 16'h9999, 1'b0, 8'h00, 8'hFF, 8'h00, 1'b0);

      // Reset during WAIT abandons the fetch; late data is dropped.
      fetch_req = 1'b1;
      tick();
      fetch_req = 1'b0;
      chk("mid_rst_req_before", rom_bus.rom_req, 1);
      do_reset();
      chk("mid_rst_req_after", rom_bus.rom_req, 0);
      chk("mid_rst_pc", pc, 8'h00);
      chk("mid_rst_ir", instruct, 0);
      rom_bus.rom_valid = 1'b1; rom_bus.rom_rdata = 16'hBEEF;
      tick();
      rom_bus.rom_valid = 1'b0;
      chk("late_valid_done", fetch_done, 0);
      chk("late_valid_ir", instruct, 0);
      chk("late_valid_pc", pc, 8'h00);
      tick();
      chk("late_valid_done2", fetch_done, 0);

      // Randomized transactions against a PC/IR model.
      mpc = 8'h00; mir = 16'h0000;
      for (int k = 0; k < 40; k++) begin
         if ($urandom % 3 == 0) begin
            sl = 1'($urandom % 2); t = 8'($urandom);
            pc_load = sl; pc_target = t;
            rom_bus.rom_valid = 1'($urandom % 2); rom_bus.rom_rdata = 16'($urandom);
            tick();
            pc_load = 1'b0; rom_bus.rom_valid = 1'b0;
            if (sl) mpc = t;
            chk("rnd_idle_pc", pc, mpc);
            chk("rnd_idle_ir", instruct, mir);
            chk("rnd_idle_done", fetch_done, 0);
         end
         l  = ($urandom % 4 == 0);
         t  = 8'($urandom);
         wt = int'($urandom % 5);
         m  = (wt > 0) && ($urandom % 3 == 0);
         mt = 8'($urandom);
         d  = 16'($urandom);
         ea = l ? t : mpc;
         ep = m ? mt : ea + 8'd1;
         do_fetch(l, t, wt, d, m, mt, ea, ep, 1'b1);
         mpc = ep; mir = d;
      end

`ifdef FETCH_TIMEOUT_EN
      // ROM never answers: NOP with error after 15 wait cycles, PC held.
      fetch_req = 1'b1;
      tick();
      fetch_req = 1'b0;
      cnt = 1;
      while (fetch_done !== 1'b1 && cnt < 40) begin
         tick();
         cnt++;
      end
      chk("to_latency", cnt, 16);
      chk("to_err", fetch_err, 1);
      chk("to_ir", instruct, 0);
      chk("to_pc", pc, mpc);
      chk("to_busy", busy, 0);
      tick();
      chk("to_err_pulse", fetch_err, 0);
      // Answer on the limit cycle completes normally.
      do_fetch(1'b0, 8'h00, 14, 16'hC0DE, 1'b0, 8'h00, mpc, mpc + 8'd1, 1'b0);
`endif

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
